// File: rtl/fp_norm_round_if.sv
// Bundle and result signals between the arithmetic front end and the
// normalize/round/pack stage.
interface fp_norm_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   s_r;
  logic [EXP_W+1:0]       exp_in;
  logic [2*MAN_W+1:0]     mant_in;
  logic                   is_nan;
  logic                   is_inf;
  logic                   is_zero;
  logic [EXP_W+MAN_W:0]   result;
  logic                   out_valid;
  logic                   overflow;
  logic                   underflow;
  logic                   inexact;

  modport master (
    output in_valid, s_r, exp_in, mant_in, is_nan, is_inf, is_zero,
    input  result, out_valid, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, s_r, exp_in, mant_in, is_nan, is_inf, is_zero,
    output result, out_valid, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_norm_round.sv
// Two-stage normalize / round-to-nearest-even / pack for single precision,
// with overflow to infinity and flush-to-zero on underflow.
module fp_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  fp_norm_round_if.slave   bus
);
  localparam int N  = 2*MAN_W + 1;
  localparam int XW = EXP_W + 3;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  // Stage 1 registers
  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [XW-1:0] s1_exp;
  logic [MAN_W:0]       s1_kept;
  logic                 s1_guard;
  logic                 s1_sticky;
  logic                 s1_nan;
  logic                 s1_inf;
  logic                 s1_zero;

  logic signed [XW-1:0] exp_ext;
  logic signed [XW-1:0] exp_n;
  logic [MAN_W:0]       kept_n;
  logic                 guard_n;
  logic                 sticky_n;
  logic                 zero_n;

  always_comb begin
    exp_ext  = {bus.exp_in[EXP_W+1], bus.exp_in};
    exp_n    = exp_ext;
    kept_n   = '0;
    guard_n  = 1'b0;
    sticky_n = 1'b0;
    zero_n   = bus.is_zero;
    if (bus.mant_in[N]) begin
      // Right shift: the bit falling off the bottom merges into sticky.
      kept_n   = bus.mant_in[N:N-MAN_W];
      guard_n  = bus.mant_in[N-MAN_W-1];
      sticky_n = |bus.mant_in[N-MAN_W-2:0];
      exp_n    = exp_ext + XW'(1);
    end else if (bus.mant_in[N-1]) begin
      kept_n   = bus.mant_in[N-1:N-1-MAN_W];
      guard_n  = bus.mant_in[N-2-MAN_W];
      sticky_n = |bus.mant_in[N-3-MAN_W:0];
    end else if (bus.mant_in[N-2]) begin
      kept_n   = bus.mant_in[N-2:N-2-MAN_W];
      guard_n  = bus.mant_in[N-3-MAN_W];
      sticky_n = |bus.mant_in[N-4-MAN_W:0];
      exp_n    = exp_ext - XW'(1);
    end else begin
      zero_n   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_kept   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
    end else if (en) begin
      s1_valid  <= bus.in_valid;
      s1_sign   <= bus.s_r;
      s1_exp    <= exp_n;
      s1_kept   <= kept_n;
      s1_guard  <= guard_n;
      s1_sticky <= sticky_n;
      s1_nan    <= bus.is_nan;
      s1_inf    <= bus.is_inf;
      s1_zero   <= zero_n;
    end
  end

  logic                 round_up;
  logic [MAN_W+1:0]     rounded;
  logic [MAN_W-1:0]     frac;
  logic signed [XW-1:0] exp_r;
  logic [EXP_W+MAN_W:0] res_n;
  logic                 ovf_n;
  logic                 unf_n;
  logic                 inx_n;

  always_comb begin
    round_up = s1_guard & (s1_sticky | s1_kept[0]);
    rounded  = {1'b0, s1_kept} + (MAN_W+2)'(round_up);
    frac     = rounded[MAN_W-1:0];
    exp_r    = s1_exp;
    res_n    = '0;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    inx_n    = 1'b0;
    if (rounded[MAN_W+1]) begin
      frac  = rounded[MAN_W:1];
      exp_r = s1_exp + XW'(1);
    end
    if (s1_nan) begin
      res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s1_inf) begin
      res_n = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s1_zero) begin
      res_n = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (!exp_r[XW-1] && exp_r >= EXP_MAX) begin
      res_n = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_n = 1'b1;
      inx_n = 1'b1;
    end else if (exp_r[XW-1] || exp_r == '0) begin
      res_n = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
      unf_n = 1'b1;
      inx_n = 1'b1;
    end else begin
      res_n = {s1_sign, exp_r[EXP_W-1:0], frac};
      inx_n = s1_guard | s1_sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      bus.result    <= '0;
      bus.out_valid <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      bus.inexact   <= 1'b0;
    end else if (en) begin
      bus.result    <= res_n;
      bus.out_valid <= s1_valid;
      bus.overflow  <= ovf_n;
      bus.underflow <= unf_n;
      bus.inexact   <= inx_n;
    end
  end
endmodule
